rx_bit_sampler: RTL and testbench

- Oversampling front end of the UART receiver. It tracks the position inside each bit period (edge_cnt) and inside the frame (bit_cnt), and majority-votes three samples of RX_IN around mid-bit into sampled_bit.
- It feeds the parity, start and stop checkers and the RX FSM. Consumers capture sampled_bit when edge_cnt == (prescale>>1)+2.

---
 rtl/rx_bit_sampler.sv | 134 +++++++++++++
 tb/tb_rx_bit_sampler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler: oversampling front end of the UART receiver.
// Synchronizes the raw serial line, tracks the edge position inside each
// bit period and the bit position inside the frame, and majority-votes three
// samples taken around mid-bit into sampled_bit.
//
// Timing at a glance (mid = prescale >> 1):
//   edge mid-1 : first vote sample captured
//   edge mid   : second vote sample captured
//   edge mid+1 : third sample taken live from rx_s, sample_done high,
//                sampled_bit loads the majority on the closing clock edge
//   edge mid+2 : sampled_bit holds the current bit (consumer capture point)
//
// sample_done and frame_end are decoded from the registered counters and
// gated by enable. Each one is high for exactly the cycle whose closing edge
// performs the update (sampled_bit load, or frame wrap). Gating by enable
// means an abort on that cycle suppresses the pulse together with the update.

module rx_bit_sampler #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       enable,
    input  logic       par_en,
    input  logic [4:0] prescale,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       sampled_bit,
    output logic       sample_done,
    output logic       frame_end
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [4:0] mid_edge;
    logic [4:0] last_edge;
    logic [4:0] vote0_edge;
    logic [4:0] vote2_edge;
    logic [3:0] last_bit;

    logic       at_last_edge;
    logic       at_last_bit;
    logic       at_vote0;
    logic       at_vote1;
    logic       at_vote2;

    // vote_q[0] and vote_q[1] hold the early samples; the third vote is
    // rx_s itself on the vote2 edge, so it never needs its own flop.
    logic [1:0] vote_q;
    logic       vote_majority;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Sample points derive from prescale with plain arithmetic; an illegal
    // prescale simply shifts them, no range protection is applied.
    assign mid_edge   = prescale >> 1;
    assign last_edge  = prescale - 5'd1;
    assign vote0_edge = mid_edge - 5'd1;
    assign vote2_edge = mid_edge + 5'd1;

    // Frame is start + data + optional parity + stop.
    assign last_bit = 4'(DATA_WIDTH + 1) + {3'b000, par_en};

    assign at_last_edge = (edge_cnt == last_edge);
    assign at_last_bit  = (bit_cnt == last_bit);
    assign at_vote0     = (edge_cnt == vote0_edge);
    assign at_vote1     = (edge_cnt == mid_edge);
    assign at_vote2     = (edge_cnt == vote2_edge);

    assign vote_majority = (vote_q[0] & vote_q[1]) |
                           (vote_q[0] & rx_s)      |
                           (vote_q[1] & rx_s);

    // Line synchronizer; resets to ones so the idle line never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
        end
    end

    // Edge and bit position counters; cleared whenever the receiver is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (!enable) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (at_last_edge) begin
            edge_cnt <= 5'd0;
            if (at_last_bit) begin
                bit_cnt <= 4'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    // Early vote samples; discarded when the frame is aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vote_q <= 2'b00;
        end else if (!enable) begin
            vote_q <= 2'b00;
        end else begin
            if (at_vote0) begin
                vote_q[0] <= rx_s;
            end
            if (at_vote1) begin
                vote_q[1] <= rx_s;
            end
        end
    end

    // Majority decision; held across idle periods so consumers keep the last bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled_bit <= 1'b0;
        end else if (enable && at_vote2) begin
            sampled_bit <= vote_majority;
        end
    end

    assign sample_done = enable & at_vote2;
    assign frame_end   = enable & at_last_edge & at_last_bit;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Bench for rx_bit_sampler: frames are described at the bit level (data,
// parity, glitch points, abort point) and expanded into a per-cycle schedule
// of line/enable stimulus plus the expected counter positions and decoded
// bit values, derived from k = cycles since enable rose.

module tb_rx_bit_sampler;

    localparam int SYNC = 2;
    localparam int DW   = 8;
    localparam int N    = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       enable;
    logic       par_en;
    logic [4:0] prescale;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_done;
    logic       frame_end;

    always #5 clk = ~clk;

    rx_bit_sampler #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .enable     (enable),
        .par_en     (par_en),
        .prescale   (prescale),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .sampled_bit(sampled_bit),
        .sample_done(sample_done),
        .frame_end  (frame_end)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // per-cycle schedule
    logic       line_a  [N];
    logic       en_a    [N];
    logic [4:0] pre_a   [N];
    logic       pe_a    [N];
    int         exp_edge[N];
    int         exp_bit [N];
    logic       exp_done[N];
    logic       exp_fend[N];
    logic       exp_val [N];
    int         line_pos;
    int         sched_len;
    logic       model_sb;

    function automatic void sched_clear();
        for (int i = 0; i < N; i++) begin
            line_a[i]   = 1'b1;
            en_a[i]     = 1'b0;
            pre_a[i]    = 5'd8;
            pe_a[i]     = 1'b0;
            exp_edge[i] = 0;
            exp_bit[i]  = 0;
            exp_done[i] = 1'b0;
            exp_fend[i] = 1'b0;
            exp_val[i]  = 1'b0;
        end
        line_pos  = 0;
        sched_len = 0;
    endfunction

    // abort_k < 0: full frame; otherwise enable is dropped on the cycle where
    // k == abort_k (gap must then be at least 1).
    function automatic void add_frame(input int p, input logic pe, input logic [7:0] data,
                                      input int gbit, input logic [2:0] gmask,
                                      input int abort_k, input int gap);
        logic bits[11];
        int   nb, act, mid, e0, b, ed;
        logic v;
        nb = DW + 2 + int'(pe);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        bits[9]  = ^data;
        bits[nb-1] = 1'b1;
        mid = p / 2;
        act = (abort_k >= 0) ? abort_k : nb * p;
        e0  = line_pos + SYNC;
        for (int k = 0; k < act; k++) begin
            b  = k / p;
            ed = k % p;
            v  = bits[b];
            if (b == gbit) begin
                for (int i = 0; i < 3; i++)
                    if (gmask[i] && ed == mid - 1 + i) v = ~v;
            end
            line_a[line_pos+k] = v;
            en_a[e0+k]     = 1'b1;
            pre_a[e0+k]    = 5'(p);
            pe_a[e0+k]     = pe;
            exp_edge[e0+k] = ed;
            exp_bit[e0+k]  = b;
            exp_done[e0+k] = (ed == mid + 1);
            exp_fend[e0+k] = (k == nb * p - 1);
            exp_val[e0+k]  = bits[b] ^ ((b == gbit) && ($countones(gmask) >= 2));
        end
        if (abort_k >= 0) begin
            exp_edge[e0+act] = act % p;
            exp_bit[e0+act]  = act / p;
        end
        line_pos  = line_pos + act + gap;
        sched_len = line_pos + SYNC + 2;
    endfunction

    // Called at posedge+1; returns at posedge+1.
    task automatic play(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            RX_IN    = line_a[c];
            enable   = en_a[c];
            prescale = pre_a[c];
            par_en   = pe_a[c];
            @(negedge clk);
            check($sformatf("edge_cnt@%0d", c),    edge_cnt,    exp_edge[c]);
            check($sformatf("bit_cnt@%0d", c),     bit_cnt,     exp_bit[c]);
            check($sformatf("sample_done@%0d", c), sample_done, exp_done[c]);
            check($sformatf("frame_end@%0d", c),   frame_end,   exp_fend[c]);
            check($sformatf("sampled_bit@%0d", c), sampled_bit, model_sb);
            if (exp_done[c]) model_sb = exp_val[c];
            @(posedge clk);
            #1;
        end
    endtask

    int         pick_p[40];
    int         nb, gap, ak, gbit, r;
    logic       pe;
    logic [2:0] gmask;

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        RX_IN    = 1'b1;
        enable   = 1'b1;
        par_en   = 1'b0;
        prescale = 5'd8;
        model_sb = 1'b0;

        // reset held with a toggling line
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 RX_IN = ~RX_IN;
            @(negedge clk);
            check("rst_edge_cnt",    edge_cnt,    0);
            check("rst_bit_cnt",     bit_cnt,     0);
            check("rst_sampled_bit", sampled_bit, 0);
            check("rst_sample_done", sample_done, 0);
            check("rst_frame_end",   frame_end,   0);
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
        RX_IN  = 1'b1;
        rst    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_edge_cnt", edge_cnt, 0);
            check("idle_bit_cnt",  bit_cnt,  0);
            @(posedge clk);
            #1;
        end

        // directed frames
        sched_clear();
        add_frame(8,  1'b0, 8'hA5, -1, 3'b000, -1, 2);
        add_frame(16, 1'b1, 8'h3C, -1, 3'b000, -1, 1);
        add_frame(16, 1'b1, 8'h01, -1, 3'b000, -1, 1);
        add_frame(8,  1'b0, 8'hA5,  1, 3'b010, -1, 0);
        add_frame(8,  1'b0, 8'hA5,  1, 3'b011, -1, 1);
        add_frame(4,  1'b0, 8'h5A, -1, 3'b000, -1, 1);
        add_frame(8,  1'b0, 8'hC3, -1, 3'b000, 3*8+2, 1);
        add_frame(8,  1'b0, 8'h96, -1, 3'b000, -1, 3);
        play(sched_len);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 2);
            pick_p[f] = (r == 0) ? 4 : ((r == 1) ? 8 : 16);
        end
        sched_clear();
        for (int f = 0; f < 40; f++) begin
            pe   = 1'($urandom_range(0, 1));
            nb   = DW + 2 + int'(pe);
            gbit = $urandom_range(0, nb - 1);
            case ($urandom_range(0, 4))
                1:       gmask = 3'b001 << $urandom_range(0, 2);
                2:       gmask = 3'b111 & ~(3'b001 << $urandom_range(0, 2));
                3:       gmask = 3'b111;
                default: gmask = 3'b000;
            endcase
            ak  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb * pick_p[f] - 1)) : -1;
            gap = $urandom_range(0, 3);
            if (ak >= 0 && gap == 0) gap = 1;
            if (f < 39 && pick_p[f+1] != pick_p[f] && gap == 0) gap = 1;
            add_frame(pick_p[f], pe, 8'($urandom), gbit, gmask, ak, gap);
        end
        play(sched_len);

        // reset in the middle of a frame
        sched_clear();
        add_frame(8, 1'b0, 8'hFF, -1, 3'b000, -1, 2);
        play(40);
        #2 rst = 1'b0;
        #1;
        check("midrst_edge_cnt",    edge_cnt,    0);
        check("midrst_bit_cnt",     bit_cnt,     0);
        check("midrst_sampled_bit", sampled_bit, 0);
        check("midrst_sample_done", sample_done, 0);
        check("midrst_frame_end",   frame_end,   0);
        enable = 1'b0;
        RX_IN  = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        model_sb = 1'b0;
        sched_clear();
        add_frame(16, 1'b1, 8'h81, -1, 3'b000, -1, 2);
        play(sched_len);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
